pattern_scan_controller: RTL and testbench
==========================================

PATTERN_SCAN_CONTROLLER -- requirements
Module: pattern_scan_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 10, the number of pattern bits scanned per run (2..15).
REQ-002 SHALL have port clock  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a scan; honoured only in IDLE.
REQ-005 SHALL have port tick  input  1  single-cycle step strobe (divided-clock enable).
REQ-006 SHALL have port pattern  input  WIDTH  word to scan, captured on the accepted start.
REQ-007 SHALL have port detect  input  1  Moore output of the external pattern detector.
REQ-008 SHALL have port shift_enable  output  1  one-cycle step strobe to the detector/datapath.
REQ-009 SHALL have port serial_out  output  1  current bit presented to the detector input.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port match_count  output  4  number of sampled detect highs in the current or last run.
REQ-013 SHALL have port bits_left  output  4  pattern bits not yet stepped.

Function
REQ-014 SHALL implement the states IDLE, SHIFT, SAMPLE and DONE.
REQ-015 IDLE with start=1 SHALL load the shadow register with pattern, set bits_left=WIDTH, clear match_count and enter SHIFT; any tick in that same cycle SHALL be ignored.
REQ-016 SHIFT with tick=1 SHALL assert shift_enable combinationally for that cycle, shift the shadow right with 0 fill at the edge, decrement bits_left and enter SAMPLE; SHIFT with tick=0 SHALL hold.
REQ-017 serial_out SHALL equal shadow bit 0 at all times, so patterns are scanned LSB-first.
REQ-018 SAMPLE SHALL last exactly one cycle, sample detect (the detector state written by the preceding step), and increment match_count when detect=1.
REQ-019 From SAMPLE: bits_left=0 SHALL go to DONE; otherwise SHALL go to SHIFT; any tick during SAMPLE SHALL be dropped, not queued.
REQ-020 DONE SHALL assert done for one cycle, then enter IDLE; match_count SHALL hold until the next accepted start.
REQ-021 start while busy=1 SHALL be ignored with no effect on state, counters or shadow.
REQ-022 match_count SHALL never exceed WIDTH; no wrap-around is possible.
REQ-023 The minimum run length SHALL be 2*WIDTH+2 cycles after start with tick held high.

Reset
REQ-024 reset_n=0 SHALL immediately force IDLE, clear the shadow, and drive shift_enable=0, serial_out=0, busy=0, done=0, match_count=0 and bits_left=0.
REQ-025 Reset asserted mid-run SHALL abandon the run with no done pulse; after release the block SHALL wait in IDLE for a new start.

Configuration
REQ-026 With PATTERN_SCAN_ABORT_EN defined, the block SHALL have an input abort (1 bit).
REQ-027 With PATTERN_SCAN_ABORT_EN, abort=1 in SHIFT, SAMPLE or DONE SHALL enter IDLE at the next edge with no done pulse and match_count held; abort SHALL win over tick and have no effect in IDLE.
REQ-028 Without PATTERN_SCAN_ABORT_EN, the abort port and its logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-029 Package pattern_scan_pkg SHALL hold the state typedef (IDLE, SHIFT, SAMPLE, DONE) and the default WIDTH constant.
REQ-030 The block SHALL be a single module with no sub-module; the detector stays external.

Verification
REQ-031 The bench SHALL model the detector as a Moore "0 then 1" detector stepped by shift_enable and fed by serial_out.
REQ-032 pattern=10'b1010101010, tick=1 -> 5 match increments, done after 22 cycles, match_count=5.
REQ-033 pattern=10'h3FF -> match_count=0; pattern=10'h000 -> match_count=0, done pulse present.
REQ-034 tick every 4th cycle, start re-pulsed mid-run -> start ignored; exactly 10 shift_enable pulses; bits_left steps 10..0.
REQ-035 reset_n=0 after the 3rd step -> all outputs 0 asynchronously, no done; the next start runs a full, clean scan.
REQ-036 With PATTERN_SCAN_ABORT_EN, abort together with tick in SHIFT -> no shift_enable, IDLE next cycle, no done pulse, match_count held.

Source files
------------

// File: rtl/pattern_scan_pkg.sv
// -----------------------------------------------------------------------------
// pattern_scan_pkg
// Shared definitions for the pattern scan controller: the controller state
// encoding and the default number of pattern bits scanned per run.
// Optional build macro used by the controller: PATTERN_SCAN_ABORT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package pattern_scan_pkg;

   localparam int DEFAULT_WIDTH = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/pattern_scan_controller.sv
// -----------------------------------------------------------------------------
// pattern_scan_controller
// Presents a captured WIDTH-bit word LSB-first to an external Moore pattern
// detector, one bit per accepted tick, and counts how many times the detector
// reports a hit after each step.
//
// Ports
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   begin a scan (accepted only in IDLE)
//   tick         in   single-cycle step strobe
//   pattern      in   word captured on an accepted start
//   detect       in   Moore output of the external detector
//   abort        in   (PATTERN_SCAN_ABORT_EN only) cancel the current run
//   shift_enable out  one-cycle step strobe to the detector
//   serial_out   out  current bit presented to the detector
//   busy         out  high in every state except IDLE
//   done         out  one-cycle completion pulse
//   match_count  out  detector hits in the current or last run
//   bits_left    out  pattern bits not yet stepped
//
// Build option: define PATTERN_SCAN_ABORT_EN to add the abort input.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module pattern_scan_controller
   import pattern_scan_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             tick,
   input  logic [WIDTH-1:0] pattern,
   input  logic             detect,
`ifdef PATTERN_SCAN_ABORT_EN
   input  logic             abort,
`endif
   output logic             shift_enable,
   output logic             serial_out,
   output logic             busy,
   output logic             done,
   output logic [3:0]       match_count,
   output logic [3:0]       bits_left
);

   localparam logic [3:0] WIDTH_BITS = 4'(WIDTH);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] shadow;
   logic             abort_req;

`ifdef PATTERN_SCAN_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Abort outranks tick, so an abort in SHIFT never produces a step strobe.
   always_comb begin
      state_next   = state;
      shift_enable = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (abort_req) begin
               state_next = IDLE;
            end else if (tick) begin
               shift_enable = 1'b1;
               state_next   = SAMPLE;
            end
         end
         SAMPLE: begin
            if (abort_req) begin
               state_next = IDLE;
            end else if (bits_left == 4'd0) begin
               state_next = DONE;
            end else begin
               state_next = SHIFT;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The detector output seen in SAMPLE already reflects the bit stepped in
   // the preceding SHIFT cycle, so counting here counts one result per bit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shadow      <= '0;
         bits_left   <= 4'd0;
         match_count <= 4'd0;
      end else begin
         if (state == IDLE && start) begin
            shadow      <= pattern;
            bits_left   <= WIDTH_BITS;
            match_count <= 4'd0;
         end else if (shift_enable) begin
            shadow    <= {1'b0, shadow[WIDTH-1:1]};
            bits_left <= bits_left - 4'd1;
         end else if (state == SAMPLE && !abort_req && detect) begin
            match_count <= match_count + 4'd1;
         end
      end
   end

   assign serial_out = shadow[0];
   assign busy       = (state != IDLE);
   assign done       = (state == DONE) && !abort_req;

endmodule

// File: tb/tb_pattern_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_pattern_scan_controller
// Directed bench for pattern_scan_controller. An external Moore "0 then 1"
// detector, stepped by shift_enable and fed by serial_out, closes the loop.
// Define PATTERN_SCAN_ABORT_EN to include the abort scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pattern_scan_controller;

   localparam int W = 10;

   logic         clock   = 1'b0;
   logic         reset_n = 1'b0;
   logic         start   = 1'b0;
   logic         tick    = 1'b0;
   logic [W-1:0] pattern = '0;
   logic         detect;
   logic         abort   = 1'b0;
   logic         shift_enable;
   logic         serial_out;
   logic         busy;
   logic         done;
   logic [3:0]   match_count;
   logic [3:0]   bits_left;

   int           n_checks   = 0;
   int           n_errors   = 0;
   int           se_total   = 0;
   int           done_total = 0;
   int           cyc_cnt    = 0;
   bit           tick_div   = 1'b0;
   logic [3:0]   bl_log[$];
   logic [1:0]   det_st;

   pattern_scan_controller #(.WIDTH(W)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start),
      .tick         (tick),
      .pattern      (pattern),
      .detect       (detect),
`ifdef PATTERN_SCAN_ABORT_EN
      .abort        (abort),
`endif
      .shift_enable (shift_enable),
      .serial_out   (serial_out),
      .busy         (busy),
      .done         (done),
      .match_count  (match_count),
      .bits_left    (bits_left)
   );

   always #5 clock = ~clock;

   // Detector: 0 = nothing, 1 = saw a 0, 2 = saw 0 followed by 1 (hit).
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         det_st <= 2'd0;
      else if (shift_enable)
         det_st <= serial_out ? ((det_st == 2'd1) ? 2'd2 : 2'd0) : 2'd1;
   end
   assign detect = (det_st == 2'd2);

   // Mid-cycle monitor: counts strobes and logs bits_left at each step.
   always @(negedge clock) begin
      if (shift_enable === 1'b1) begin
         se_total++;
         bl_log.push_back(bits_left);
      end
      if (done === 1'b1) done_total++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #2;
      cyc_cnt++;
      if (tick_div) tick = (cyc_cnt % 4 == 0);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      cyc();
      cyc();
      reset_n = 1'b1;
      cyc();
   endtask

   // Returns the number of rising edges from the accepting edge up to and
   // including the edge that raises done (400 means it never came).
   task automatic run_scan(input logic [W-1:0] pat, input bit repulse, output int edges);
      bit pulsed = 1'b0;
      int base_se;
      pattern = pat;
      start   = 1'b1;
      cyc();
      start   = 1'b0;
      pattern = '0;
      edges   = 1;
      base_se = se_total;
      while (done !== 1'b1 && edges < 400) begin
         if (repulse && !pulsed && (se_total - base_se) == 5) begin
            start   = 1'b1;
            pattern = '1;
            pulsed  = 1'b1;
         end
         cyc();
         start = 1'b0;
         edges++;
      end
   endtask

   initial begin
      int e;
      int b_se;
      int b_done;
      int b_log;
      int n;

      // Reset state
      #1;
      chk("rst_shift_enable", shift_enable, 0);
      chk("rst_serial_out", serial_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_match_count", match_count, 0);
      chk("rst_bits_left", bits_left, 0);
      apply_reset();

      // Alternating pattern, tick held high
      tick = 1'b1;
      b_se = se_total; b_done = done_total;
      run_scan(10'b1010101010, 1'b0, e);
      chk("alt_edges_to_done", e, 21);
      chk("alt_match_count", match_count, 5);
      cyc();
      chk("alt_done_pulses", done_total - b_done, 1);
      chk("alt_shift_pulses", se_total - b_se, 10);
      chk("alt_done_low", done, 0);
      chk("alt_busy_low", busy, 0);
      chk("alt_bits_left", bits_left, 0);
      cyc(); cyc();
      chk("alt_match_hold", match_count, 5);

      // All ones: no 0-then-1 transition
      b_done = done_total;
      run_scan(10'h3FF, 1'b0, e);
      chk("ones_edges_to_done", e, 21);
      chk("ones_match_count", match_count, 0);
      cyc();
      chk("ones_done_pulses", done_total - b_done, 1);

      // All zeros: still completes with a done pulse
      b_done = done_total;
      run_scan(10'h000, 1'b0, e);
      chk("zeros_match_count", match_count, 0);
      cyc();
      chk("zeros_done_pulses", done_total - b_done, 1);

      // Slow tick, start re-pulsed mid-run with a different word
      apply_reset();
      tick_div = 1'b1;
      tick = 1'b0;
      b_se = se_total; b_done = done_total; b_log = bl_log.size();
      run_scan(10'b1100110011, 1'b1, e);
      chk("slow_match_count", match_count, 2);
      cyc();
      tick_div = 1'b0;
      tick = 1'b1;
      chk("slow_shift_pulses", se_total - b_se, 10);
      chk("slow_done_pulses", done_total - b_done, 1);
      chk("slow_bits_left_end", bits_left, 0);
      n = bl_log.size() - b_log;
      chk("slow_bits_log_len", n, 10);
      if (n > 10) n = 10;
      for (int i = 0; i < n; i++)
         chk($sformatf("slow_bits_left_step%0d", i), bl_log[b_log + i], 10 - i);

      // Reset after the third step
      apply_reset();
      tick = 1'b1;
      b_se = se_total; b_done = done_total;
      pattern = 10'b1010101010;
      start = 1'b1;
      cyc();
      start = 1'b0;
      e = 0;
      while ((se_total - b_se) < 3 && e < 50) begin
         cyc();
         e++;
      end
      chk("rmid_reached_step3", se_total - b_se, 3);
      chk("rmid_busy_before", busy, 1);
      chk("rmid_match_before", match_count, 1);
      reset_n = 1'b0;
      #1;
      chk("rmid_shift_enable", shift_enable, 0);
      chk("rmid_serial_out", serial_out, 0);
      chk("rmid_busy", busy, 0);
      chk("rmid_done", done, 0);
      chk("rmid_match_count", match_count, 0);
      chk("rmid_bits_left", bits_left, 0);
      cyc(); cyc();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      chk("rmid_idle_after", busy, 0);
      chk("rmid_no_done", done_total - b_done, 0);
      run_scan(10'b1010101010, 1'b0, e);
      chk("rmid_rerun_edges", e, 21);
      chk("rmid_rerun_match", match_count, 5);
      cyc();

`ifdef PATTERN_SCAN_ABORT_EN
      // Abort together with tick while waiting in SHIFT
      apply_reset();
      tick = 1'b1;
      b_done = done_total;
      pattern = 10'b1010101010;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      tick = 1'b0;
      cyc();
      chk("abort_busy_before", busy, 1);
      chk("abort_match_before", match_count, 1);
      abort = 1'b1;
      tick  = 1'b1;
      #1;
      chk("abort_no_shift", shift_enable, 0);
      cyc();
      abort = 1'b0;
      chk("abort_idle_next", busy, 0);
      chk("abort_match_held", match_count, 1);
      cyc(); cyc(); cyc();
      chk("abort_no_done", done_total - b_done, 0);
      chk("abort_stays_idle", busy, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
